// File: rtl/fft_bar_sequencer.sv
// Frame sequencer for the spectrum bar writer: fetches one FFT magnitude per bar,
// scales/saturates it to a 7-bit height and hands it to the writer, left channel first.
module fft_bar_sequencer #(
  parameter int BAR_COUNT = 64,
  parameter int IDX_W     = 6,
  parameter int MAG_SHIFT = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             FrameStart,
  input  logic             TopEnable,
  output logic             MagRdEn,
  output logic [IDX_W:0]   MagAddr,
  input  logic [15:0]      MagData,
  output logic             WrStart,
  output logic [6:0]       Bar,
  input  logic             WrEnd,
  output logic             NewFrame,
  output logic             LRChange,
  output logic             DrawTop,
  output logic             Busy,
  output logic             FrameDone,
  output logic             Overrun
);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, START, WAIT_END, NEXT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BAR_COUNT - 1);

  state_t           state, state_nxt;
  logic             chan, chan_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             pending, pending_nxt;
  logic             first, first_nxt;
  logic             draw_top_nxt;
  logic             overrun_nxt;
  logic [6:0]       bar_nxt;
  logic             accept;
  logic             last_bar;

  function automatic logic [6:0] sat_bar(input logic [15:0] mag);
    logic [15:0] h;
    h = mag >> MAG_SHIFT;
    return (h > 16'd127) ? 7'd127 : h[6:0];
  endfunction

  assign last_bar = (idx == LAST_IDX);

  always_comb begin
    state_nxt    = state;
    chan_nxt     = chan;
    idx_nxt      = idx;
    pending_nxt  = pending;
    first_nxt    = first;
    draw_top_nxt = DrawTop;
    overrun_nxt  = 1'b0;
    bar_nxt      = Bar;
    accept       = 1'b0;

    // One trigger may queue behind the running frame; any further one is dropped.
    if (state != IDLE && FrameStart) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end

    case (state)
      IDLE:     if (FrameStart || pending) accept = 1'b1;
      FETCH: begin
        first_nxt = 1'b0;
        state_nxt = DATA;
      end
      DATA: begin
        bar_nxt   = sat_bar(MagData);
        state_nxt = START;
      end
      START:    state_nxt = WAIT_END;
      WAIT_END: if (WrEnd) state_nxt = NEXT;
      NEXT: begin
        if (!last_bar) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = FETCH;
        end else if (!chan) begin
          chan_nxt  = 1'b1;
          idx_nxt   = '0;
          state_nxt = FETCH;
        end else if (pending) begin
          accept = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase

    if (accept) begin
      pending_nxt  = 1'b0;
      chan_nxt     = 1'b0;
      idx_nxt      = '0;
      draw_top_nxt = TopEnable;
      first_nxt    = 1'b1;
      state_nxt    = FETCH;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      chan    <= 1'b0;
      idx     <= '0;
      pending <= 1'b0;
      first   <= 1'b0;
      DrawTop <= 1'b0;
      Overrun <= 1'b0;
      Bar     <= '0;
    end else begin
      state   <= state_nxt;
      chan    <= chan_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
      first   <= first_nxt;
      DrawTop <= draw_top_nxt;
      Overrun <= overrun_nxt;
      Bar     <= bar_nxt;
    end
  end

  // Strobes are pure state decodes so no input reaches an output combinationally.
  assign MagRdEn   = (state == FETCH);
  assign MagAddr   = {chan, idx};
  assign NewFrame  = (state == FETCH) && first;
  assign WrStart   = (state == START);
  assign LRChange  = (state == NEXT) && last_bar && !chan;
  assign FrameDone = (state == NEXT) && last_bar && chan;
  assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_fft_bar_sequencer.sv
// Directed bench for fft_bar_sequencer with a 4-bar configuration, a registered
// magnitude buffer model and a bar writer model with programmable End latency.
module tb_fft_bar_sequencer;

  logic        Clock;
  logic        Reset;
  logic        FrameStart;
  logic        TopEnable;
  logic        MagRdEn;
  logic [2:0]  MagAddr;
  logic [15:0] MagData;
  logic        WrStart;
  logic [6:0]  Bar;
  logic        WrEnd;
  logic        NewFrame;
  logic        LRChange;
  logic        DrawTop;
  logic        Busy;
  logic        FrameDone;
  logic        Overrun;

  fft_bar_sequencer #(.BAR_COUNT(4), .IDX_W(2), .MAG_SHIFT(4)) dut (
    .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .TopEnable(TopEnable),
    .MagRdEn(MagRdEn), .MagAddr(MagAddr), .MagData(MagData), .WrStart(WrStart),
    .Bar(Bar), .WrEnd(WrEnd), .NewFrame(NewFrame), .LRChange(LRChange),
    .DrawTop(DrawTop), .Busy(Busy), .FrameDone(FrameDone), .Overrun(Overrun)
  );

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem [0:7];
  int wr_delay  = 10;
  int spur_cyc  = -1;

  int cyc = 0;
  int ws_cnt = 0, rd_cnt = 0, nf_cnt = 0, lr_cnt = 0, fd_cnt = 0, ov_cnt = 0;
  int ws_cyc [0:255];
  int ws_bar [0:255];
  int rd_cyc [0:255];
  int rd_addr[0:255];
  int nf_cyc [0:255];
  int lr_cyc [0:255];
  int fd_cyc [0:255];
  logic       rd_pend = 1'b0;
  logic [2:0] rd_a    = '0;
  int wcnt = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Buffer, writer and event log, all evaluated 1 time unit after each edge.
  initial begin
    MagData = '0;
    WrEnd   = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (rd_pend) MagData = mem[rd_a];
      rd_pend = MagRdEn;
      rd_a    = MagAddr;
      if (MagRdEn)   begin rd_cyc[rd_cnt] = cyc; rd_addr[rd_cnt] = int'(MagAddr); rd_cnt++; end
      if (WrStart)   begin ws_cyc[ws_cnt] = cyc; ws_bar[ws_cnt] = int'(Bar); ws_cnt++; end
      if (NewFrame)  begin nf_cyc[nf_cnt] = cyc; nf_cnt++; end
      if (LRChange)  begin lr_cyc[lr_cnt] = cyc; lr_cnt++; end
      if (FrameDone) begin fd_cyc[fd_cnt] = cyc; fd_cnt++; end
      if (Overrun)   ov_cnt++;
      WrEnd = 1'b0;
      if (Reset) begin
        wcnt = 0;
      end else begin
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) WrEnd = 1'b1;
        end
        if (WrStart) wcnt = wr_delay;
      end
      if (cyc == spur_cyc) WrEnd = 1'b1;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic load_default_mem();
    for (int a = 0; a < 8; a++) mem[a] = 16'(16 * (a + 1));
  endtask

  task automatic test_reset();
    Reset = 1'b1; FrameStart = 1'b0; TopEnable = 1'b0;
    tick(); tick();
    checks++;
    if ({MagRdEn, MagAddr, WrStart, Bar, NewFrame, LRChange, DrawTop, Busy, FrameDone, Overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {MagRdEn, MagAddr, WrStart, Bar, NewFrame, LRChange, DrawTop, Busy, FrameDone, Overrun});
    end
    Reset = 1'b0;
    tick(); tick();
    checks++;
    if (Busy !== 1'b0 || MagRdEn !== 1'b0) begin
      fails++; $display("FAIL reset_idle: Busy=%b MagRdEn=%b required 0 0", Busy, MagRdEn);
    end
  endtask

  task automatic test_basic_frame();
    int bws, bnf, blr, bfd, brd, n;
    bws = ws_cnt; bnf = nf_cnt; blr = lr_cnt; bfd = fd_cnt; brd = rd_cnt;
    wr_delay = 10; TopEnable = 1'b1;
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    n = 0;
    while (fd_cnt < bfd + 1 && n < 1000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (fd_cnt - bfd !== 1) begin fails++; $display("FAIL basic_framedone: got %0d required 1", fd_cnt - bfd); end
    checks++;
    if (ws_cnt - bws !== 8) begin fails++; $display("FAIL basic_wrstarts: got %0d required 8", ws_cnt - bws); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ws_bar[bws + i] !== i + 1) begin
        fails++; $display("FAIL basic_bar%0d: got %0d required %0d", i, ws_bar[bws + i], i + 1);
      end
    end
    checks++;
    if (nf_cnt - bnf !== 1) begin fails++; $display("FAIL basic_newframe: got %0d required 1", nf_cnt - bnf); end
    checks++;
    if (lr_cnt - blr !== 1) begin fails++; $display("FAIL basic_lrchange_count: got %0d required 1", lr_cnt - blr); end
    checks++;
    if (!(lr_cyc[blr] > ws_cyc[bws + 3] && lr_cyc[blr] + 1 == rd_cyc[brd + 4])) begin
      fails++; $display("FAIL basic_lrchange_pos: LRChange cycle %0d, left bar 3 start %0d, right fetch %0d",
                        lr_cyc[blr], ws_cyc[bws + 3], rd_cyc[brd + 4]);
    end
    checks++;
    if (rd_addr[brd + 4] !== 4) begin fails++; $display("FAIL basic_right_addr: got %0d required 4", rd_addr[brd + 4]); end
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b required 0", Busy); end
    checks++;
    if (DrawTop !== 1'b1) begin fails++; $display("FAIL basic_drawtop: got %b required 1", DrawTop); end
  endtask

  task automatic test_saturation();
    int bws, bfd, n;
    int exp_bar [0:7];
    mem[0] = 16'h07F0; mem[1] = 16'h0800; mem[2] = 16'hFFFF; mem[3] = 16'h000F;
    mem[4] = 16'h0010; mem[5] = 16'h0FFF; mem[6] = 16'h0000; mem[7] = 16'h07EF;
    exp_bar = '{127, 127, 127, 0, 1, 127, 0, 126};
    bws = ws_cnt; bfd = fd_cnt;
    wr_delay = 2;
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    n = 0;
    while (fd_cnt < bfd + 1 && n < 1000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (ws_cnt - bws !== 8) begin fails++; $display("FAIL sat_wrstarts: got %0d required 8", ws_cnt - bws); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ws_bar[bws + i] !== exp_bar[i]) begin
        fails++; $display("FAIL sat_bar%0d: got %0d required %0d", i, ws_bar[bws + i], exp_bar[i]);
      end
    end
    load_default_mem();
  endtask

  task automatic test_cycle_timing();
    int bws, bnf, brd, bfd, c0, n;
    bws = ws_cnt; bnf = nf_cnt; brd = rd_cnt; bfd = fd_cnt;
    wr_delay = 17;
    FrameStart = 1'b1; c0 = cyc; tick(); FrameStart = 1'b0;
    n = 0;
    while (fd_cnt < bfd + 1 && n < 2000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (nf_cyc[bnf] - c0 !== 1) begin fails++; $display("FAIL timing_newframe: cycle %0d required 1", nf_cyc[bnf] - c0); end
    checks++;
    if (rd_cyc[brd] - c0 !== 1) begin fails++; $display("FAIL timing_rden0: cycle %0d required 1", rd_cyc[brd] - c0); end
    checks++;
    if (ws_cyc[bws] - c0 !== 3) begin fails++; $display("FAIL timing_wrstart0: cycle %0d required 3", ws_cyc[bws] - c0); end
    checks++;
    if (rd_cyc[brd + 1] - c0 !== 22) begin fails++; $display("FAIL timing_rden1: cycle %0d required 22", rd_cyc[brd + 1] - c0); end
    checks++;
    if (ws_cyc[bws + 1] - c0 !== 24) begin fails++; $display("FAIL timing_wrstart1: cycle %0d required 24", ws_cyc[bws + 1] - c0); end
  endtask

  task automatic test_back_to_back();
    int bws, bnf, bfd, bov, brd, n, drops;
    bws = ws_cnt; bnf = nf_cnt; bfd = fd_cnt; bov = ov_cnt; brd = rd_cnt;
    wr_delay = 3;
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    drops = 0; n = 0;
    while (fd_cnt < bfd + 2 && n < 2000) begin
      if (!Busy) drops++;
      FrameStart = (n == 5 || n == 8);
      tick();
      n++;
    end
    FrameStart = 1'b0;
    checks++;
    if (drops !== 0) begin fails++; $display("FAIL b2b_busy_gap: got %0d idle cycles required 0", drops); end
    tick();
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b required 0", Busy); end
    tick(); tick(); tick();
    checks++;
    if (fd_cnt - bfd !== 2) begin fails++; $display("FAIL b2b_framedone: got %0d required 2", fd_cnt - bfd); end
    checks++;
    if (nf_cnt - bnf !== 2) begin fails++; $display("FAIL b2b_newframe: got %0d required 2", nf_cnt - bnf); end
    checks++;
    if (nf_cyc[bnf + 1] !== fd_cyc[bfd] + 1) begin
      fails++; $display("FAIL b2b_restart: NewFrame cycle %0d required %0d", nf_cyc[bnf + 1], fd_cyc[bfd] + 1);
    end
    checks++;
    if (ov_cnt - bov !== 1) begin fails++; $display("FAIL b2b_overrun: got %0d required 1", ov_cnt - bov); end
    checks++;
    if (ws_cnt - bws !== 16) begin fails++; $display("FAIL b2b_wrstarts: got %0d required 16", ws_cnt - bws); end
    checks++;
    if (rd_addr[brd + 8] !== 0) begin fails++; $display("FAIL b2b_second_addr: got %0d required 0", rd_addr[brd + 8]); end
  endtask

  task automatic test_spurious_drawtop();
    int bws, brd, bfd, c0, n;
    bws = ws_cnt;
    spur_cyc = cyc + 1;
    tick(); tick(); tick();
    checks++;
    if (Busy !== 1'b0 || MagRdEn !== 1'b0 || ws_cnt !== bws) begin
      fails++; $display("FAIL spur_idle: Busy=%b MagRdEn=%b starts=%0d required 0 0 0", Busy, MagRdEn, ws_cnt - bws);
    end
    brd = rd_cnt; bfd = fd_cnt;
    wr_delay = 6; TopEnable = 1'b0;
    FrameStart = 1'b1; c0 = cyc; spur_cyc = c0 + 1; tick(); FrameStart = 1'b0;
    TopEnable = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (DrawTop !== 1'b0) begin fails++; $display("FAIL drawtop_midframe: got %b required 0", DrawTop); end
    n = 0;
    while (fd_cnt < bfd + 1 && n < 1000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (ws_cyc[bws] - c0 !== 3) begin fails++; $display("FAIL spur_fetch_start: cycle %0d required 3", ws_cyc[bws] - c0); end
    checks++;
    if (rd_cyc[brd + 1] - c0 !== 11) begin fails++; $display("FAIL spur_fetch_next: cycle %0d required 11", rd_cyc[brd + 1] - c0); end
    checks++;
    if (ws_cnt - bws !== 8) begin fails++; $display("FAIL spur_wrstarts: got %0d required 8", ws_cnt - bws); end
    checks++;
    if (DrawTop !== 1'b0) begin fails++; $display("FAIL drawtop_after: got %b required 0", DrawTop); end
  endtask

  task automatic test_reset_midframe();
    int bws, brd, bnf, bfd, n;
    bws = ws_cnt; brd = rd_cnt;
    wr_delay = 30; TopEnable = 1'b1;
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    n = 0;
    while (ws_cnt < bws + 3 && n < 1000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (DrawTop !== 1'b1 || MagAddr !== 3'd2 || Bar !== 7'd3) begin
      fails++; $display("FAIL rst_pre: DrawTop=%b MagAddr=%0d Bar=%0d required 1 2 3", DrawTop, MagAddr, Bar);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({MagRdEn, MagAddr, WrStart, Bar, NewFrame, LRChange, DrawTop, Busy, FrameDone, Overrun} !== '0) begin
      fails++;
      $display("FAIL rst_async_outputs: got %b required all zero",
               {MagRdEn, MagAddr, WrStart, Bar, NewFrame, LRChange, DrawTop, Busy, FrameDone, Overrun});
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (ws_cnt !== bws + 3 || rd_cnt !== brd + 3) begin
      fails++; $display("FAIL rst_quiet: starts=%0d reads=%0d required 3 3", ws_cnt - bws, rd_cnt - brd);
    end
    bnf = nf_cnt; bfd = fd_cnt;
    wr_delay = 2;
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    n = 0;
    while (fd_cnt < bfd + 1 && n < 1000) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (rd_addr[brd + 3] !== 0) begin fails++; $display("FAIL rst_restart_addr: got %0d required 0", rd_addr[brd + 3]); end
    checks++;
    if (ws_bar[bws + 3] !== 1 || nf_cnt - bnf !== 1) begin
      fails++; $display("FAIL rst_restart_frame: bar=%0d newframes=%0d required 1 1", ws_bar[bws + 3], nf_cnt - bnf);
    end
  endtask

  initial begin
    Reset = 1'b1; FrameStart = 1'b0; TopEnable = 1'b0;
    load_default_mem();
    test_reset();
    test_basic_frame();
    test_saturation();
    test_cycle_timing();
    test_back_to_back();
    test_spurious_drawtop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
